mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single data-memory bus (RAM plus the peripheral address window) between two requesters: port 0 is the CPU memory stage, port 1 is a secondary master such as a program loader or DMA. It arbitrates per access with round-robin priority and decodes the top three address bits into RAM or peripheral targets. It sequences the fixed-latency read return and produces a stall signal for the pipeline. It sits between `memory`/loader and `ram`/`peripheral_manager` inside `cpu`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `READ_LAT`, default 1: cycles from read issue to read data valid at the RAM/peripheral outputs. Must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `m0_req`, `m1_req` in 1: access request.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in ADDR_W: byte address.
- `m0_wdata`, `m1_wdata` in DATA_W: write data.
- `m0_gnt`, `m1_gnt` out 1: access accepted this cycle.
- `m0_rvalid`, `m1_rvalid` out 1: one-cycle pulse; `mN_rdata` is valid.
- `m0_rdata`, `m1_rdata` out DATA_W: read data.
- `cpu_stall` out 1: `m0_req & ~m0_gnt`.
- `ram_address` out ADDR_W; `ram_data_in` out DATA_W; `ram_write_enable` out 1; `ram_data_out` in DATA_W.
- `per_sel` out 3: peripheral index, 1..7; `per_addr` out ADDR_W; `per_data_in` out DATA_W; `per_write_enable` out 1; `per_rdata` in DATA_W.

## Operation
- Address map: `addr[ADDR_W-1:ADDR_W-3]` is the region. 000 = RAM; 001..111 = peripheral 1..7. The forwarded address is `addr` with the top 3 bits cleared.
- FSM states:
  - IDLE: accepts one request per cycle.
  - RD_WAIT: waits for read data. Entered on a granted read. A `lat_cnt` counter is loaded with READ_LAT−1; the FSM returns to IDLE when `lat_cnt` reaches 0 and the data-return cycle completes.
- Arbitration in IDLE, combinational:
  - If only one master requests, that master is granted.
  - If both request, the master not granted last wins. The `last` register updates on every grant and resets to 1, so m0 wins the first tie.
- No grants are issued in RD_WAIT. Requests are held pending.
- Grant cycle:
  - The granted master's addr/wdata are muxed onto the target bus.
  - `ram_write_enable` or `per_write_enable` is asserted for exactly this cycle if `we`=1.
  - The non-target bus keeps its write-enable at 0.
- Writes complete in the grant cycle and the FSM stays in IDLE, giving back-to-back throughput of 1 access per cycle.
- Reads:
  - The target and owner are latched at grant.
  - On the data-return cycle, `ram_data_out` or `per_rdata` is registered into the owner's `rdata`, and `rvalid` pulses on the following edge.
- Requesters must hold req/we/addr/wdata stable until `gnt`. Behaviour is undefined otherwise.
- `rdata` holds its last value between reads.

## Timing
- Reset values (applied asynchronously while `rst`=0):
  - state IDLE, `last`=1, `lat_cnt`=0.
  - All `gnt`, `rvalid`, and write enables are 0.
  - `rdata` = 0.
  - `per_sel` = 0.
  - Bus address/data outputs are 0.
- `gnt` is combinational from state and requests, and asserts in the same cycle as `req` when the FSM is IDLE.
- Read latency is request-to-`rvalid` = READ_LAT+1 cycles, counted from the grant edge. Next grant is possible in the cycle after `rvalid`.
- Reset asserted mid-read: the transaction is dropped and no `rvalid` is produced.
- A simultaneous new request in the data-return cycle waits until IDLE.
- `lat_cnt` width: `$clog2(READ_LAT+1)`. It saturates at 0 and never wraps.

## Structure
- Shared package `mem_map_pkg`: region constants `REGION_RAM=3'b000`, region field position, and FSM state enum `{IDLE, RD_WAIT}`.
- One natural sub-module: `rr_arbiter2`, a 2-input round-robin grant with the `last` register.
- Address decode and FSM live in the top block.

## Test plan
- Reset: hold `rst`=0 with both reqs high → all gnt/we/rvalid are 0. Release → m0 is granted first.
- Single write: m0 write to 0x0000_0010 with data 0xDEADBEEF → `m0_gnt` and `ram_write_enable` high for 1 cycle, `ram_address`=0x10, `per_write_enable`=0.
- Peripheral decode: m1 write to 0x2000_0004 with data 5 → `per_sel`=1, `per_addr`=0x4, `per_write_enable` pulse, RAM untouched.
- Tie and fairness: both masters issue 4 continuous writes → grants alternate m0, m1, m0, m1. `cpu_stall`=1 exactly in the cycles where m1 is granted.
- Read with READ_LAT=2: m0 reads 0x10, RAM model returns 0x1234 → `m0_rvalid` 3 cycles after grant with `rdata`=0x1234. An m1 request during the wait is granted only after `rvalid`.
- Reset mid-read: assert `rst` one cycle after the read grant → no `rvalid`, FSM in IDLE, next request is granted immediately after release.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared definitions for the data-memory bus: address region field, target
// encoding and the bus FSM states.
package mem_map_pkg;

  localparam int              REGION_W   = 3;
  localparam logic [REGION_W-1:0] REGION_RAM = 3'b000;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  typedef enum logic {
    TGT_RAM,
    TGT_PER
  } target_e;

  // Lowest bit index of the region field for a given address width.
  function automatic int region_lsb(input int addr_w);
    return addr_w - REGION_W;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. On a tie the master not granted last wins;
// the history bit starts at 1 so master 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0]) begin
      last_d = 1'b0;
    end else if (gnt[1]) begin
      last_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-memory bus between the CPU memory stage (m0) and a
// secondary master (m1): round-robin grant, region decode, read return.
module mem_bus_arbiter
  import mem_map_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              cpu_stall,

  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out,

  output logic [2:0]        per_sel,
  output logic [ADDR_W-1:0] per_addr,
  output logic [DATA_W-1:0] per_data_in,
  output logic              per_write_enable,
  input  logic [DATA_W-1:0] per_rdata
);

  localparam int              REG_LSB  = region_lsb(ADDR_W);
  localparam int              LAT_W    = $clog2(READ_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);

  state_e              state_q,   state_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                owner_q,   owner_d;
  target_e             tgt_q,     tgt_d;
  logic [1:0]          rvalid_q,  rvalid_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic [1:0]          gnt;
  logic                arb_en;
  logic                granted;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [REGION_W-1:0] region;
  logic [ADDR_W-1:0]   offset;
  target_e             sel_tgt;
  logic [DATA_W-1:0]   rdata_src;

  // The reset pin also gates grants so nothing is accepted while reset is held.
  assign arb_en = (state_q == IDLE) && rst;

  rr_arbiter2 u_rr_arbiter2 (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  assign granted   = |gnt;
  assign sel_we    = gnt[1] ? m1_we    : m0_we;
  assign sel_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
  assign region    = sel_addr[ADDR_W-1:REG_LSB];
  assign offset    = {{REGION_W{1'b0}}, sel_addr[REG_LSB-1:0]};
  assign sel_tgt   = (region == REGION_RAM) ? TGT_RAM : TGT_PER;
  assign rdata_src = (tgt_q == TGT_PER) ? per_rdata : ram_data_out;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ram_address      = '0;
    ram_data_in      = '0;
    ram_write_enable = 1'b0;
    per_sel          = '0;
    per_addr         = '0;
    per_data_in      = '0;
    per_write_enable = 1'b0;
    if (granted) begin
      if (sel_tgt == TGT_RAM) begin
        ram_address      = offset;
        ram_data_in      = sel_wdata;
        ram_write_enable = sel_we;
      end else begin
        per_sel          = region;
        per_addr         = offset;
        per_data_in      = sel_wdata;
        per_write_enable = sel_we;
      end
    end
  end

  // The rvalid cycle is still spent in RD_WAIT; the next grant follows it.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    owner_d    = owner_q;
    tgt_d      = tgt_q;
    rvalid_d   = 2'b00;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (granted && !sel_we) begin
          state_d   = RD_WAIT;
          lat_cnt_d = LAT_LOAD;
          owner_d   = gnt[1];
          tgt_d     = sel_tgt;
        end
      end
      RD_WAIT: begin
        if (|rvalid_q) begin
          state_d = IDLE;
        end else if (lat_cnt_q == '0) begin
          if (owner_q) begin
            m1_rdata_d  = rdata_src;
            rvalid_d[1] = 1'b1;
          end else begin
            m0_rdata_d  = rdata_src;
            rvalid_d[0] = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      owner_q    <= 1'b0;
      tgt_q      <= TGT_RAM;
      rvalid_q   <= 2'b00;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      tgt_q      <= tgt_d;
      rvalid_q   <= rvalid_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign cpu_stall = m0_req & ~gnt[0];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with READ_LAT=2: directed vector
// table, hand-written read/reset sequences and a randomized phase.
module tb_mem_bus_arbiter;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, cpu_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_address, ram_data_in, ram_data_out;
  logic        ram_write_enable, per_write_enable;
  logic [2:0]  per_sel;
  logic [31:0] per_addr, per_data_in, per_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cpu_stall(cpu_stall),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out),
    .per_sel(per_sel), .per_addr(per_addr), .per_data_in(per_data_in),
    .per_write_enable(per_write_enable), .per_rdata(per_rdata)
  );

  // Fixed-latency RAM and peripheral models: region 0 is RAM, 1..7 peripherals.
  bit [31:0] dev_mem [8][256];
  bit [31:0] ram_pipe [RL];
  bit [31:0] per_pipe [RL];

  always @(posedge clk) begin
    ram_pipe[0] <= dev_mem[0][ram_address[9:2]];
    per_pipe[0] <= dev_mem[per_sel][per_addr[9:2]];
    for (int i = 1; i < RL; i++) begin
      ram_pipe[i] <= ram_pipe[i-1];
      per_pipe[i] <= per_pipe[i-1];
    end
    if (ram_write_enable) dev_mem[0][ram_address[9:2]] <= ram_data_in;
    if (per_write_enable) dev_mem[per_sel][per_addr[9:2]] <= per_data_in;
  end

  assign ram_data_out = ram_pipe[RL-1];
  assign per_rdata    = per_pipe[RL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index, when the bus is next free, tie history,
  // one outstanding read and a word-addressed shadow of memory contents.
  int          cyc = 0;
  int          busy_until = 0;
  bit          last_m = 1'b1;
  bit          rd_pending = 1'b0;
  bit          rd_owner;
  int          rd_cycle;
  logic [31:0] rd_data;
  logic [31:0] rdata_exp [2];
  logic [31:0] ref_mem [logic [31:0]];
  bit          exp_g0, exp_g1;

  task automatic model_reset();
    busy_until   = cyc;
    last_m       = 1'b1;
    rd_pending   = 1'b0;
    rdata_exp[0] = '0;
    rdata_exp[1] = '0;
  endtask

  // Called at the falling edge: predicts and compares all outputs of this cycle.
  task automatic model_step();
    bit          rv0, rv1, wwe;
    logic [31:0] wa, wd;
    logic [2:0]  rgn;
    exp_g0 = 1'b0;
    exp_g1 = 1'b0;
    if (cyc >= busy_until) begin
      if (m0_req && m1_req) begin
        if (last_m) exp_g0 = 1'b1; else exp_g1 = 1'b1;
      end else if (m0_req) begin
        exp_g0 = 1'b1;
      end else if (m1_req) begin
        exp_g1 = 1'b1;
      end
    end
    check("m0_gnt", m0_gnt, exp_g0);
    check("m1_gnt", m1_gnt, exp_g1);
    check("cpu_stall", cpu_stall, m0_req && !exp_g0);
    rv0 = 1'b0;
    rv1 = 1'b0;
    if (rd_pending && rd_cycle == cyc) begin
      if (rd_owner) rv1 = 1'b1; else rv0 = 1'b1;
      rdata_exp[rd_owner] = rd_data;
      rd_pending = 1'b0;
    end
    check("m0_rvalid", m0_rvalid, rv0);
    check("m1_rvalid", m1_rvalid, rv1);
    check("m0_rdata", m0_rdata, rdata_exp[0]);
    check("m1_rdata", m1_rdata, rdata_exp[1]);
    if (exp_g0 || exp_g1) begin
      wwe = exp_g1 ? m1_we    : m0_we;
      wa  = exp_g1 ? m1_addr  : m0_addr;
      wd  = exp_g1 ? m1_wdata : m0_wdata;
      rgn = wa[31:29];
      check("ram_we", ram_write_enable, wwe && rgn == 3'd0);
      check("per_we", per_write_enable, wwe && rgn != 3'd0);
      check("per_sel", per_sel, rgn);
      if (rgn == 3'd0) check("ram_address", ram_address, wa & 32'h1FFF_FFFF);
      else             check("per_addr", per_addr, wa & 32'h1FFF_FFFF);
      if (wwe) begin
        if (rgn == 3'd0) check("ram_data_in", ram_data_in, wd);
        else             check("per_data_in", per_data_in, wd);
        ref_mem[wa] = wd;
      end else begin
        rd_pending = 1'b1;
        rd_owner   = exp_g1;
        rd_cycle   = cyc + RL + 1;
        rd_data    = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
        busy_until = cyc + RL + 2;
      end
      last_m = exp_g1;
    end else begin
      check("ram_we_idle", ram_write_enable, 1'b0);
      check("per_we_idle", per_write_enable, 1'b0);
      check("per_sel_idle", per_sel, 3'd0);
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic        g0, g1, ram_we, per_we;
    logic [2:0]  sel;
    logic [31:0] baddr, bdata;
    logic        stall;
  } vec_t;

  vec_t vecs [9];

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } pend_t;

  function automatic pend_t new_access();
    pend_t       p;
    logic [2:0]  rgn;
    logic [5:0]  idx;
    rgn    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    idx    = 6'($urandom_range(0, 63));
    p.req  = 1'b1;
    p.we   = $urandom_range(0, 1) == 1;
    p.addr = {rgn, 21'b0, idx, 2'b00};
    p.data = $urandom;
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int    rv_at, g1_at;
    logic [31:0] rv_data;
    pend_t p0, p1;

    vecs[0] = '{1,0,1,0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 1,0,1,0, 3'd0, 32'h10, 32'hDEADBEEF, 0};
    vecs[1] = '{0,1,0,1, 32'h0, 32'h2000_0004, 32'h0, 32'h5, 0,1,0,1, 3'd1, 32'h4, 32'h5, 0};
    vecs[2] = '{1,1,1,1, 32'h20, 32'h4000_0008, 32'hA0, 32'hB0, 1,0,1,0, 3'd0, 32'h20, 32'hA0, 0};
    vecs[3] = '{1,1,1,1, 32'h20, 32'h4000_0008, 32'hA0, 32'hB0, 0,1,0,1, 3'd2, 32'h8, 32'hB0, 1};
    vecs[4] = '{1,1,1,1, 32'h20, 32'h4000_0008, 32'hA1, 32'hB1, 1,0,1,0, 3'd0, 32'h20, 32'hA1, 0};
    vecs[5] = '{1,1,1,1, 32'h24, 32'h4000_0008, 32'hA2, 32'hB1, 0,1,0,1, 3'd2, 32'h8, 32'hB1, 1};
    vecs[6] = '{0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 0,0,0,0, 3'd0, 32'h0, 32'h0, 0};
    vecs[7] = '{1,0,1,0, 32'hE000_0100, 32'h0, 32'h77, 32'h0, 1,0,0,1, 3'd7, 32'h100, 32'h77, 0};
    vecs[8] = '{0,1,0,1, 32'h0, 32'h1FFF_FFFC, 32'h0, 32'h55, 0,1,1,0, 3'd0, 32'h1FFF_FFFC, 32'h55, 0};

    // Reset held with both masters requesting: nothing may be accepted.
    rst = 1'b0;
    drive(1, 1, 32'h40, 32'h11, 1, 1, 32'h44, 32'h22);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_m0_gnt", m0_gnt, 1'b0);
      check("rst_m1_gnt", m1_gnt, 1'b0);
      check("rst_ram_we", ram_write_enable, 1'b0);
      check("rst_per_we", per_write_enable, 1'b0);
      check("rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
      check("rst_per_sel", per_sel, 3'd0);
      check("rst_bus_addr", ram_address | per_addr, 32'h0);
      advance();
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("first_tie_m0", {m1_gnt, m0_gnt}, 2'b01);
    model_step();
    advance();

    // Directed write vectors.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      check($sformatf("v%0d_gnt", i), {m1_gnt, m0_gnt}, {vecs[i].g1, vecs[i].g0});
      check($sformatf("v%0d_we", i), {ram_write_enable, per_write_enable},
            {vecs[i].ram_we, vecs[i].per_we});
      check($sformatf("v%0d_sel", i), per_sel, vecs[i].sel);
      check($sformatf("v%0d_stall", i), cpu_stall, vecs[i].stall);
      if ((vecs[i].g0 || vecs[i].g1) && !vecs[i].per_we) begin
        check($sformatf("v%0d_ram_addr", i), ram_address, vecs[i].baddr);
        check($sformatf("v%0d_ram_data", i), ram_data_in, vecs[i].bdata);
        check($sformatf("v%0d_per_we_off", i), per_addr, 32'h0);
      end else if (vecs[i].g0 || vecs[i].g1) begin
        check($sformatf("v%0d_per_addr", i), per_addr, vecs[i].baddr);
        check($sformatf("v%0d_per_data", i), per_data_in, vecs[i].bdata);
        check($sformatf("v%0d_ram_off", i), ram_address, 32'h0);
      end else begin
        check($sformatf("v%0d_idle_bus", i), ram_address | per_addr, 32'h0);
      end
      model_step();
      advance();
    end

    // Read with m1 arriving during the wait.
    drive(1, 1, 32'h10, 32'h1234, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    model_step();
    advance();
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    rv_at   = -1;
    g1_at   = -1;
    rv_data = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) check("rd_grant", m0_gnt, 1'b1);
      if (m0_rvalid && rv_at < 0) begin
        rv_at   = k;
        rv_data = m0_rdata;
      end
      if (m1_gnt && g1_at < 0) g1_at = k;
      model_step();
      advance();
      if (k == 0) begin
        m0_req = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h30, 32'h99);
      end
      if (g1_at == k) m1_req = 1'b0;
    end
    check("rd_rvalid_cycle", rv_at, 3);
    check("rd_rdata", rv_data, 32'h1234);
    check("rd_m1_after_rvalid", g1_at, 4);

    // Reset one cycle after a read grant.
    drive(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("mid_rd_grant", m0_gnt, 1'b1);
    model_step();
    advance();
    rst = 1'b0;
    model_reset();
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h34, 32'h42);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_rvalid", {m1_rvalid, m0_rvalid}, 2'b00);
      check("mid_rst_gnt", m1_gnt, 1'b0);
      advance();
    end
    rst = 1'b1;
    @(negedge clk);
    check("gnt_after_release", m1_gnt, 1'b1);
    model_step();
    advance();
    m1_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      model_step();
      advance();
    end

    // Randomized traffic; each master holds its access until granted.
    p0 = '{req: 1'b0, we: 1'b0, addr: 32'h0, data: 32'h0};
    p1 = p0;
    for (int n = 0; n < 1500; n++) begin
      if (!p0.req && $urandom_range(0, 1) == 1) p0 = new_access();
      if (!p1.req && $urandom_range(0, 1) == 1) p1 = new_access();
      drive(p0.req, p0.we, p0.addr, p0.data, p1.req, p1.we, p1.addr, p1.data);
      @(negedge clk);
      model_step();
      advance();
      if (exp_g0) p0.req = 1'b0;
      if (exp_g1) p1.req = 1'b0;
    end
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int k = 0; k < RL + 3; k++) begin
      @(negedge clk);
      model_step();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
